str_chk: RTL and testbench

//   Synthesizable passive observer for the tvalid/tready/tvalue stream bus.

---
 rtl/str_chk.sv | 144 ++++++++++++++
 tb/tb_str_chk.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/str_chk.sv
// ---------------------------------------------------------------------------
// str_chk -- passive observer for a tvalid/tready/tvalue stream link.
//
// Watches the link without driving it. It checks the handshake rules,
// counts transfers and backpressure, and latches protocol violations in
// sticky flags.
//
// Parameters
//   VW          width of the observed tvalue
//   CW          width of every statistics counter (all saturate at 2^CW-1)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   tvalid      observed bus valid
//   tready      observed bus ready
//   tvalue      observed bus value
//   clr         synchronous clear of counters and error flags
//   xfer        registered pulse, one cycle after each transfer
//   last_value  value of the most recent transfer
//   xfer_cnt    number of transfers (tvalid & tready)
//   stall_cnt   number of cycles with tvalid & ~tready
//   stall_max   longest stall run that ended in a transfer
//   err_drop    sticky: tvalid fell while a transfer was pending
//   err_chg     sticky: tvalue changed while a transfer was pending
// ---------------------------------------------------------------------------
module str_chk #(
  parameter int VW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tvalid,
  input  logic          tready,
  input  logic [VW-1:0] tvalue,
  input  logic          clr,
  output logic          xfer,
  output logic [VW-1:0] last_value,
  output logic [CW-1:0] xfer_cnt,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] stall_max,
  output logic          err_drop,
  output logic          err_chg
);

  typedef enum logic {
    IDLE = 1'b0,   // no transfer pending
    WAIT = 1'b1    // valid seen with ready low; held value under watch
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state;
  logic [VW-1:0] held;
  logic [CW-1:0] run;

  // Cycle classification of the current bus sample.
  logic xfer_now;
  logic stall_now;
  logic drop_now;
  logic chg_now;

  assign xfer_now  = tvalid & tready;
  assign stall_now = tvalid & ~tready;
  // Violations only exist while a transfer is pending. The change check
  // also covers the cycle in which the pending transfer finally completes.
  assign drop_now  = (state == WAIT) & ~tvalid;
  assign chg_now   = (state == WAIT) & tvalid & (tvalue != held);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      held       <= '0;
      run        <= '0;
      xfer       <= 1'b0;
      last_value <= '0;
      xfer_cnt   <= '0;
      stall_cnt  <= '0;
      stall_max  <= '0;
      err_drop   <= 1'b0;
      err_chg    <= 1'b0;
    end else begin
      // Observation path: unaffected by clr.
      xfer <= xfer_now;
      if (xfer_now) begin
        last_value <= tvalue;
      end

      case (state)
        IDLE: begin
          if (stall_now) begin
            state <= WAIT;
            held  <= tvalue;
            run   <= CW'(1);
          end
        end
        WAIT: begin
          if (!tvalid || tready) begin
            // Either the source gave up or the transfer completed.
            state <= IDLE;
            run   <= '0;
          end else begin
            run <= sat_inc(run);
          end
        end
        default: begin
          state <= IDLE;
          run   <= '0;
        end
      endcase

      // Statistics and flags: clr takes priority over any update.
      if (clr) begin
        xfer_cnt  <= '0;
        stall_cnt <= '0;
        stall_max <= '0;
        err_drop  <= 1'b0;
        err_chg   <= 1'b0;
      end else begin
        if (xfer_now) begin
          xfer_cnt <= sat_inc(xfer_cnt);
          // run is zero for a transfer taken straight from IDLE.
          if (run > stall_max) begin
            stall_max <= run;
          end
        end
        if (stall_now) begin
          stall_cnt <= sat_inc(stall_cnt);
        end
        if (drop_now) begin
          err_drop <= 1'b1;
        end
        if (chg_now) begin
          err_chg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_str_chk.sv
// ---------------------------------------------------------------------------
// tb_str_chk -- self-checking bench for str_chk.
// Two instances watch the same stimulus: one with 16-bit counters and one
// with 4-bit counters, so saturation is exercised by the same traffic.
// A reference model keeps raw (unbounded) counts and applies saturation
// only when comparing.
// ---------------------------------------------------------------------------
module tb_str_chk;
  localparam int VW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tvalid = 1'b0;
  logic          tready = 1'b0;
  logic          clr = 1'b0;
  logic [VW-1:0] tvalue = '0;

  logic          xfer_a, edrop_a, echg_a;
  logic [VW-1:0] last_a;
  logic [15:0]   xcnt_a, scnt_a, smax_a;
  logic          xfer_b, edrop_b, echg_b;
  logic [VW-1:0] last_b;
  logic [3:0]    xcnt_b, scnt_b, smax_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  str_chk #(.VW(VW), .CW(16)) dut (
    .clk(clk), .rst(rst), .tvalid(tvalid), .tready(tready), .tvalue(tvalue),
    .clr(clr), .xfer(xfer_a), .last_value(last_a), .xfer_cnt(xcnt_a),
    .stall_cnt(scnt_a), .stall_max(smax_a), .err_drop(edrop_a), .err_chg(echg_a)
  );

  str_chk #(.VW(VW), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .tvalid(tvalid), .tready(tready), .tvalue(tvalue),
    .clr(clr), .xfer(xfer_b), .last_value(last_b), .xfer_cnt(xcnt_b),
    .stall_cnt(scnt_b), .stall_max(smax_b), .err_drop(edrop_b), .err_chg(echg_b)
  );

  // ---------------- reference model ----------------
  // "pending" means a value was offered and not yet accepted.
  logic          m_pend = 1'b0;
  logic [VW-1:0] m_held = '0;
  logic [VW-1:0] m_last = '0;
  logic          m_xfer = 1'b0;
  logic          m_edrop = 1'b0;
  logic          m_echg = 1'b0;
  int            m_run = 0;
  int            m_xcnt = 0;
  int            m_scnt = 0;
  int            m_smax = 0;

  function automatic int sat(input int x, input int lim);
    return (x > lim) ? lim : x;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend = 0; m_held = '0; m_last = '0; m_xfer = 0; m_edrop = 0; m_echg = 0;
      m_run = 0; m_xcnt = 0; m_scnt = 0; m_smax = 0;
    end else begin
      logic xf, st;
      xf = tvalid && tready;
      st = tvalid && !tready;
      if (m_pend && !tvalid) m_edrop = 1;
      if (m_pend && tvalid && (tvalue != m_held)) m_echg = 1;
      if (xf) begin
        m_xcnt++;
        m_last = tvalue;
        if (m_run > m_smax) m_smax = m_run;
      end
      if (st) begin
        m_scnt++;
        if (!m_pend) m_held = tvalue;
        m_run++;
      end else begin
        m_run = 0;
      end
      m_pend = st;
      m_xfer = xf;
      if (clr) begin
        m_xcnt = 0; m_scnt = 0; m_smax = 0; m_edrop = 0; m_echg = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic r, input logic [VW-1:0] val, input logic c);
    tvalid = v; tready = r; tvalue = val; clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    drive(0, 0, '0, 1);
    tick();
    drive(0, 0, '0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if ({xfer_a, last_a, xcnt_a, scnt_a, smax_a, edrop_a, echg_a} !== '0) begin failures++; $display("FAIL reset_async_a got=%h exp=0", {xfer_a, last_a, xcnt_a, scnt_a, smax_a, edrop_a, echg_a}); end
    checks++; if ({xfer_b, last_b, xcnt_b, scnt_b, smax_b, edrop_b, echg_b} !== '0) begin failures++; $display("FAIL reset_async_b got=%h exp=0", {xfer_b, last_b, xcnt_b, scnt_b, smax_b, edrop_b, echg_b}); end
    drive(1, 1, 32'h5, 0);
    tick();
    checks++; if ({xfer_a, xcnt_a, last_a} !== '0) begin failures++; $display("FAIL reset_held got=%h exp=0", {xfer_a, xcnt_a, last_a}); end
    rst = 1'b1;
    drive(0, 0, '0, 0);
    tick();
    $display("reset: done");
  endtask

  task automatic test_back_to_back();
    clear_stats();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, VW'(i), 0);
      tick();
      checks++; if (xfer_a !== 1'b1) begin failures++; $display("FAIL b2b_xfer_pulse cycle=%0d got=%b exp=1", i, xfer_a); end
    end
    drive(0, 0, '0, 0);
    tick();
    checks++; if (xfer_a !== 1'b0) begin failures++; $display("FAIL b2b_xfer_end got=%b exp=0", xfer_a); end
    checks++; if (xcnt_a !== 16'd4) begin failures++; $display("FAIL b2b_xfer_cnt got=%0d exp=4", xcnt_a); end
    checks++; if (scnt_a !== 16'd0) begin failures++; $display("FAIL b2b_stall_cnt got=%0d exp=0", scnt_a); end
    checks++; if (last_a !== 32'd4) begin failures++; $display("FAIL b2b_last_value got=%0d exp=4", last_a); end
    $display("back_to_back: xfer_cnt=%0d last=%0d", xcnt_a, last_a);
  endtask

  task automatic test_stall();
    clear_stats();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'hA5, 0);
      tick();
    end
    checks++; if (xfer_a !== 1'b0) begin failures++; $display("FAIL stall_no_xfer got=%b exp=0", xfer_a); end
    drive(1, 1, 32'hA5, 0);
    tick();
    drive(0, 0, '0, 0);
    checks++; if (xfer_a !== 1'b1) begin failures++; $display("FAIL stall_xfer got=%b exp=1", xfer_a); end
    checks++; if (scnt_a !== 16'd3) begin failures++; $display("FAIL stall_stall_cnt got=%0d exp=3", scnt_a); end
    checks++; if (smax_a !== 16'd3) begin failures++; $display("FAIL stall_stall_max got=%0d exp=3", smax_a); end
    checks++; if (xcnt_a !== 16'd1) begin failures++; $display("FAIL stall_xfer_cnt got=%0d exp=1", xcnt_a); end
    checks++; if (last_a !== 32'hA5) begin failures++; $display("FAIL stall_last_value got=%h exp=a5", last_a); end
    checks++; if ({edrop_a, echg_a} !== 2'b00) begin failures++; $display("FAIL stall_errors got=%b exp=00", {edrop_a, echg_a}); end
    tick();
    $display("stall: stall_cnt=%0d stall_max=%0d", scnt_a, smax_a);
  endtask

  task automatic test_drop();
    clear_stats();
    drive(1, 0, 32'h33, 0);
    tick();
    drive(0, 0, '0, 0);
    tick();
    checks++; if (edrop_a !== 1'b1) begin failures++; $display("FAIL drop_flag got=%b exp=1", edrop_a); end
    checks++; if (xcnt_a !== 16'd0) begin failures++; $display("FAIL drop_xfer_cnt got=%0d exp=0", xcnt_a); end
    drive(1, 1, 32'h44, 0);
    tick();
    drive(0, 0, '0, 0);
    checks++; if (xcnt_a !== 16'd1) begin failures++; $display("FAIL drop_next_xfer got=%0d exp=1", xcnt_a); end
    checks++; if (edrop_a !== 1'b1) begin failures++; $display("FAIL drop_sticky got=%b exp=1", edrop_a); end
    tick();
    $display("drop: err_drop=%b xfer_cnt=%0d", edrop_a, xcnt_a);
  endtask

  task automatic test_change();
    clear_stats();
    drive(1, 0, 32'h11, 0);
    tick();
    checks++; if (echg_a !== 1'b0) begin failures++; $display("FAIL chg_early got=%b exp=0", echg_a); end
    drive(1, 0, 32'h22, 0);
    tick();
    checks++; if (echg_a !== 1'b1) begin failures++; $display("FAIL chg_flag got=%b exp=1", echg_a); end
    drive(1, 1, 32'h22, 0);
    tick();
    drive(0, 0, '0, 0);
    checks++; if (xcnt_a !== 16'd1) begin failures++; $display("FAIL chg_xfer_cnt got=%0d exp=1", xcnt_a); end
    checks++; if (last_a !== 32'h22) begin failures++; $display("FAIL chg_last_value got=%h exp=22", last_a); end
    checks++; if ({edrop_a, echg_a} !== 2'b01) begin failures++; $display("FAIL chg_flags got=%b exp=01", {edrop_a, echg_a}); end
    tick();
    $display("change: err_chg=%b last=%h", echg_a, last_a);
  endtask

  task automatic test_saturation_clr();
    clear_stats();
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, VW'(i), 0);
      tick();
    end
    checks++; if (xcnt_b !== 4'd15) begin failures++; $display("FAIL sat_xfer_cnt4 got=%0d exp=15", xcnt_b); end
    checks++; if (xcnt_a !== 16'd20) begin failures++; $display("FAIL sat_xfer_cnt16 got=%0d exp=20", xcnt_a); end
    drive(1, 1, 32'h55, 1);
    tick();
    checks++; if ({xcnt_a, xcnt_b} !== 20'd0) begin failures++; $display("FAIL clr_xfer_cnt got=%0d/%0d exp=0/0", xcnt_a, xcnt_b); end
    checks++; if ({xfer_a, xfer_b} !== 2'b11) begin failures++; $display("FAIL clr_xfer_pulse got=%b exp=11", {xfer_a, xfer_b}); end
    checks++; if (last_b !== 32'h55) begin failures++; $display("FAIL clr_last_value got=%h exp=55", last_b); end
    drive(1, 1, 32'h56, 0);
    tick();
    drive(0, 0, '0, 0);
    checks++; if (xcnt_b !== 4'd1) begin failures++; $display("FAIL clr_resume got=%0d exp=1", xcnt_b); end
    tick();
    $display("saturation_clr: xfer_cnt4=%0d", xcnt_b);
  endtask

  task automatic test_async_reset();
    clear_stats();
    drive(1, 1, 32'h70, 0);
    tick();
    drive(1, 0, 32'h77, 0);
    tick();
    #2 rst = 1'b0;
    #1;
    checks++; if ({xfer_a, last_a, xcnt_a, scnt_a, smax_a, edrop_a, echg_a} !== '0) begin failures++; $display("FAIL arst_outputs got=%h exp=0", {xfer_a, last_a, xcnt_a, scnt_a, smax_a, edrop_a, echg_a}); end
    tick();
    rst = 1'b1;
    drive(0, 0, '0, 0);
    tick();
    checks++; if (edrop_a !== 1'b0) begin failures++; $display("FAIL arst_no_drop got=%b exp=0", edrop_a); end
    drive(1, 1, 32'h78, 0);
    tick();
    drive(0, 0, '0, 0);
    checks++; if (xcnt_a !== 16'd1) begin failures++; $display("FAIL arst_next_xfer got=%0d exp=1", xcnt_a); end
    checks++; if ({edrop_a, echg_a} !== 2'b00) begin failures++; $display("FAIL arst_errors got=%b exp=00", {edrop_a, echg_a}); end
    tick();
    $display("async_reset: xfer_cnt=%0d err_drop=%b", xcnt_a, edrop_a);
  endtask

  task automatic test_random();
    int ready_div;
    for (int n = 0; n < 3000; n++) begin
      // Second half favours long stalls so the 4-bit run counter saturates.
      ready_div = (n < 1500) ? 2 : 12;
      tvalid = ($urandom_range(0, 5) != 0);
      tready = ($urandom_range(0, ready_div - 1) == 0);
      if (m_pend && $urandom_range(0, 15) != 0) tvalue = m_held;
      else tvalue = VW'($urandom_range(0, 3));
      clr = ($urandom_range(0, 199) == 0);
      tick();
      checks++; if (xfer_a !== m_xfer) begin failures++; $display("FAIL rnd_xfer_a n=%0d got=%b exp=%b", n, xfer_a, m_xfer); end
      checks++; if (last_a !== m_last) begin failures++; $display("FAIL rnd_last_a n=%0d got=%h exp=%h", n, last_a, m_last); end
      checks++; if (xcnt_a !== 16'(sat(m_xcnt, 65535))) begin failures++; $display("FAIL rnd_xfer_cnt_a n=%0d got=%0d exp=%0d", n, xcnt_a, sat(m_xcnt, 65535)); end
      checks++; if (scnt_a !== 16'(sat(m_scnt, 65535))) begin failures++; $display("FAIL rnd_stall_cnt_a n=%0d got=%0d exp=%0d", n, scnt_a, sat(m_scnt, 65535)); end
      checks++; if (smax_a !== 16'(sat(m_smax, 65535))) begin failures++; $display("FAIL rnd_stall_max_a n=%0d got=%0d exp=%0d", n, smax_a, sat(m_smax, 65535)); end
      checks++; if ({edrop_a, echg_a} !== {m_edrop, m_echg}) begin failures++; $display("FAIL rnd_errs_a n=%0d got=%b exp=%b", n, {edrop_a, echg_a}, {m_edrop, m_echg}); end
      checks++; if ({xfer_b, last_b} !== {m_xfer, m_last}) begin failures++; $display("FAIL rnd_obs_b n=%0d got=%h exp=%h", n, {xfer_b, last_b}, {m_xfer, m_last}); end
      checks++; if (xcnt_b !== 4'(sat(m_xcnt, 15))) begin failures++; $display("FAIL rnd_xfer_cnt_b n=%0d got=%0d exp=%0d", n, xcnt_b, sat(m_xcnt, 15)); end
      checks++; if (scnt_b !== 4'(sat(m_scnt, 15))) begin failures++; $display("FAIL rnd_stall_cnt_b n=%0d got=%0d exp=%0d", n, scnt_b, sat(m_scnt, 15)); end
      checks++; if (smax_b !== 4'(sat(m_smax, 15))) begin failures++; $display("FAIL rnd_stall_max_b n=%0d got=%0d exp=%0d", n, smax_b, sat(m_smax, 15)); end
      checks++; if ({edrop_b, echg_b} !== {m_edrop, m_echg}) begin failures++; $display("FAIL rnd_errs_b n=%0d got=%b exp=%b", n, {edrop_b, echg_b}, {m_edrop, m_echg}); end
    end
    drive(0, 0, '0, 0);
    tick();
    $display("random: xfers=%0d stalls=%0d stall_max=%0d", m_xcnt, m_scnt, m_smax);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_drop();
    test_change();
    test_saturation_clr();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
